// File: rtl/uart8_receiver_os_if.sv
// uart8_receiver_os_if
//   Bundles the receiver's control, serial-line and byte-delivery signals.
//   slave  : the receiver side (consumes en/in/ready, drives the rest)
//   master : the system side (drives en/in/ready, observes the rest)
// Signals:
//   en        receive enable
//   in        RX serial line, asynchronous, idle high
//   out       received byte, meaningful while valid is high
//   valid     byte available, held until consumed
//   ready     consumer accepts the byte when valid & ready
//   busy      receiver is inside a frame (not idle)
//   frame_err one-cycle pulse: stop bit sampled low
//   overrun   one-cycle pulse: unconsumed byte overwritten
interface uart8_receiver_os_if;
  logic       en;
  logic       in;
  logic [7:0] out;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  modport master (
    output en, in, ready,
    input  out, valid, busy, frame_err, overrun
  );

  modport slave (
    input  en, in, ready,
    output out, valid, busy, frame_err, overrun
  );
endinterface

// File: rtl/uart8_receiver_os.sv
// uart8_receiver_os
//   Oversampling 8N1 UART receiver. The clock runs at OVERSAMPLE x baud.
//   The RX line is brought in through a two-flop synchroniser, the start bit
//   is qualified at its midpoint, eight data bits are taken LSB-first at
//   mid-bit and the stop bit is checked. Good bytes land in a valid/ready
//   holding register; a byte that overwrites an unconsumed one pulses
//   overrun, a low stop bit pulses frame_err.
// Ports:
//   clk  oversampled clock
//   rst  asynchronous reset, active high
//   bus  uart8_receiver_os_if.slave (en, in, ready in; out, valid, busy,
//        frame_err, overrun out)
// Parameter:
//   OVERSAMPLE  clock cycles per bit (even, >= 8)
// Build option:
//   UART_RX_MAJORITY_EN  when defined, each bit decision is the 2-of-3 vote
//   of the synchronised line over the current and two preceding cycles, so a
//   single-cycle glitch at mid-bit is rejected. Undefined: the synchronised
//   line at the decision cycle is used directly.
module uart8_receiver_os #(
  parameter int OVERSAMPLE = 16
) (
  input logic                    clk,
  input logic                    rst,
  uart8_receiver_os_if.slave     bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  logic          sync1_r;
  logic          sync2_r;   // synchronised line (rx_s)
  logic          bit_s;     // bit decision value
  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    idx_r;
  logic [7:0]    data_r;
  logic          busy_r;
  logic          deliver_r; // good stop seen; load holding register next cycle
  logic          ferr_r;
  logic [7:0]    out_r;
  logic          valid_r;
  logic          ovr_r;

  // Two-flop synchroniser for the asynchronous RX line; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= bus.in;
      sync2_r <= sync1_r;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic vote1_r;
  logic vote2_r;

  // History of the synchronised line for the 2-of-3 vote.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vote1_r <= 1'b1;
      vote2_r <= 1'b1;
    end else begin
      vote1_r <= sync2_r;
      vote2_r <= vote1_r;
    end
  end

  assign bit_s = (sync2_r & vote1_r) | (sync2_r & vote2_r) | (vote1_r & vote2_r);
`else
  assign bit_s = sync2_r;
`endif

  // Frame FSM: start qualification, mid-bit sampling, stop check, break recovery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      idx_r     <= 3'd0;
      data_r    <= 8'h00;
      busy_r    <= 1'b0;
      deliver_r <= 1'b0;
      ferr_r    <= 1'b0;
    end else begin
      deliver_r <= 1'b0;
      ferr_r    <= 1'b0;
      if (!bus.en) begin
        // Disable drops any partial frame without reporting it.
        state_r <= ST_IDLE;
        cnt_r   <= '0;
        idx_r   <= 3'd0;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            cnt_r <= '0;
            if (!sync2_r) begin
              state_r <= ST_START;
              busy_r  <= 1'b1;
            end else begin
              busy_r  <= 1'b0;
            end
          end
          ST_START: begin
            if (cnt_r == CNT_MID) begin
              cnt_r <= '0;
              idx_r <= 3'd0;
              if (bit_s) begin
                // Line back high at mid-start: treat as a glitch.
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
              end else begin
                state_r <= ST_DATA;
              end
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
          ST_DATA: begin
            if (cnt_r == CNT_END) begin
              cnt_r         <= '0;
              data_r[idx_r] <= bit_s;
              if (idx_r == 3'd7) begin
                state_r <= ST_STOP;
              end else begin
                idx_r <= idx_r + 3'd1;
              end
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
          ST_STOP: begin
            if (cnt_r == CNT_END) begin
              cnt_r <= '0;
              if (bit_s) begin
                deliver_r <= 1'b1;
                state_r   <= ST_IDLE;
                busy_r    <= 1'b0;
              end else begin
                ferr_r  <= 1'b1;
                state_r <= ST_RECOVER;
              end
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
          ST_RECOVER: begin
            // A held-low (break) line must not look like a new start bit.
            cnt_r <= '0;
            if (sync2_r) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_RECOVER;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            idx_r   <= 3'd0;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Holding register: load on delivery, clear on handshake, flag overwrites.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r   <= 8'h00;
      valid_r <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      ovr_r <= 1'b0;
      if (deliver_r) begin
        out_r   <= data_r;
        valid_r <= 1'b1;
        ovr_r   <= valid_r & ~bus.ready;
      end else if (valid_r & bus.ready) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign bus.out       = out_r;
  assign bus.valid     = valid_r;
  assign bus.busy      = busy_r;
  assign bus.frame_err = ferr_r;
  assign bus.overrun   = ovr_r;

endmodule

// File: tb/tb_uart8_receiver_os.sv
// tb_uart8_receiver_os
//   Self-checking bench for uart8_receiver_os (OVERSAMPLE = 16). Frames are
//   generated bit by bit on the serial line; expected bytes come from a
//   frame-level model and are matched against every valid/ready handshake.
module tb_uart8_receiver_os;
  localparam int OS      = 16;
  localparam int LATENCY = 9 * OS + OS / 2 + 3;

  logic clk;
  logic rst;
  uart8_receiver_os_if bus ();

  uart8_receiver_os #(.OVERSAMPLE(OS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int e0       = 0;
  logic rand_ready = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: mid-bit sampling recovers the byte unless a glitch sits
  // on each sample point, which only the majority vote can ignore.
  function automatic logic [7:0] model_byte(input logic [7:0] d, input logic glitch);
`ifdef UART_RX_MAJORITY_EN
    return d;
`else
    return glitch ? ~d : d;
`endif
  endfunction

  // Observation counters and the expected-byte scoreboard.
  logic [7:0] exp_q[$];
  logic valid_q = 1'b0;
  logic busy_q  = 1'b0;
  int n_vrise, vhigh, n_ferr, n_ovr, n_brise, bhigh, rise_cyc;
  logic [7:0] rise_out;

  task automatic clear_counts();
    n_vrise = 0; vhigh = 0; n_ferr = 0; n_ovr = 0; n_brise = 0; bhigh = 0;
    rise_cyc = 0; rise_out = 8'h00;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid && !valid_q) begin
        n_vrise++;
        rise_cyc = cyc;
        rise_out = bus.out;
      end
      if (bus.valid) vhigh++;
      if (bus.frame_err) n_ferr++;
      if (bus.overrun) n_ovr++;
      if (bus.busy && !busy_q) n_brise++;
      if (bus.busy) bhigh++;
      if (bus.valid && bus.ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL rx_byte: got unexpected byte %0h, required none", bus.out);
        end else begin
          check("rx_byte", {24'h0, bus.out}, {24'h0, exp_q.pop_front()});
        end
      end
    end
    valid_q = bus.valid;
    busy_q  = bus.busy;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.ready = 1'($urandom_range(0, 1));
    end
  endtask

  // One 8N1 frame, OS cycles per bit; optional one-cycle inversion at each
  // data-bit sample point. Leaves the line idle high.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic glitch);
    logic v;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < OS; c++) begin
        if (b == 0) v = 1'b0;
        else if (b == 9) v = stop_bit;
        else v = data[b-1];
        if (glitch && b >= 1 && b <= 8 && c == OS / 2) v = ~v;
        if (b == 0 && c == 0) e0 = cyc + 1;
        bus.in = v;
        tick(1);
      end
    end
    bus.in = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       glitch;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] rdata;
  logic       bad;
  int         exp_ferr;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h55, 1'b0, 1'b0};
    vecs[4] = '{8'h0F, 1'b1, 1'b0};
    vecs[5] = '{8'h96, 1'b1, 1'b1};

    rst = 1'b1; bus.en = 1'b1; bus.in = 1'b1; bus.ready = 1'b1;
    clear_counts();
    tick(3);
    check("rst_out", {24'h0, bus.out}, 32'h0);
    check("rst_valid", {31'h0, bus.valid}, 32'h0);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_ferr", {31'h0, bus.frame_err}, 32'h0);
    check("rst_ovr", {31'h0, bus.overrun}, 32'h0);
    rst = 1'b0;
    tick(4);

    // Single frames with ready held high.
    for (int i = 0; i < 6; i++) begin
      clear_counts();
      if (vecs[i].stop) exp_q.push_back(model_byte(vecs[i].data, vecs[i].glitch));
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].glitch);
      tick(2 * OS);
      check("vec_valid_rises", n_vrise, {31'h0, vecs[i].stop});
      check("vec_valid_cycles", vhigh, {31'h0, vecs[i].stop});
      check("vec_frame_err", n_ferr, {31'h0, ~vecs[i].stop});
      check("vec_overrun", n_ovr, 32'h0);
      if (vecs[i].stop) begin
        check("vec_latency", rise_cyc - e0, LATENCY);
        check("vec_out", {24'h0, rise_out}, {24'h0, model_byte(vecs[i].data, vecs[i].glitch)});
      end
    end

    // Overrun: two bytes with no consumer, then one handshake.
    clear_counts();
    bus.ready = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0);
    tick(OS);
    send_frame(8'h81, 1'b1, 1'b0);
    tick(4);
    check("ovr_pulses", n_ovr, 32'd1);
    check("ovr_out", {24'h0, bus.out}, 32'h81);
    check("ovr_valid", {31'h0, bus.valid}, 32'h1);
    exp_q.push_back(8'h81);
    bus.ready = 1'b1;
    tick(1);
    check("ovr_valid_drop", {31'h0, bus.valid}, 32'h0);
    check("ovr_out_hold", {24'h0, bus.out}, 32'h81);

    // Framing error followed by a 40-bit-time break, then a clean frame.
    clear_counts();
    send_frame(8'h55, 1'b0, 1'b0);
    bus.in = 1'b0;
    tick(40 * OS);
    check("brk_busy_held", {31'h0, bus.busy}, 32'h1);
    bus.in = 1'b1;
    tick(2 * OS);
    check("brk_ferr", n_ferr, 32'd1);
    check("brk_no_valid", n_vrise, 32'd0);
    check("brk_no_retrigger", n_brise, 32'd1);
    check("brk_idle", {31'h0, bus.busy}, 32'h0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 1'b0);
    tick(2 * OS);
    check("brk_next_valid", n_vrise, 32'd1);

    // Short low glitch on an idle line.
    clear_counts();
    bus.in = 1'b0;
    tick(4);
    bus.in = 1'b1;
    tick(2 * OS);
    check("glt_busy_seen", {31'h0, bhigh > 0}, 32'h1);
    check("glt_busy_le10", {31'h0, bhigh <= 10}, 32'h1);
    check("glt_no_valid", n_vrise, 32'd0);
    check("glt_no_ferr", n_ferr, 32'd0);

    // Reset in the middle of a frame while a byte is held.
    clear_counts();
    bus.ready = 1'b0;
    send_frame(8'h12, 1'b1, 1'b0);
    tick(4);
    check("rstm_pre_valid", {31'h0, bus.valid}, 32'h1);
    fork
      send_frame(8'h33, 1'b1, 1'b0);
      begin
        tick(4 * OS);
        rst = 1'b1;
        #1;
        check("rstm_out", {24'h0, bus.out}, 32'h0);
        check("rstm_valid", {31'h0, bus.valid}, 32'h0);
        check("rstm_busy", {31'h0, bus.busy}, 32'h0);
      end
    join
    rst = 1'b0;
    bus.ready = 1'b1;
    tick(4);
    clear_counts();
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b1, 1'b0);
    tick(2 * OS);
    check("rstm_next_valid", n_vrise, 32'd1);

    // Enable dropped mid-frame.
    clear_counts();
    fork
      send_frame(8'h77, 1'b1, 1'b0);
      begin
        tick(4 * OS);
        bus.en = 1'b0;
        tick(2);
        check("en_busy_drop", {31'h0, bus.busy}, 32'h0);
      end
    join
    bus.en = 1'b1;
    tick(4);
    check("en_no_valid", n_vrise, 32'd0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0);
    tick(2 * OS);
    check("en_next_valid", n_vrise, 32'd1);

    // Randomised frames, gaps, stop errors and consumer stalls.
    clear_counts();
    exp_ferr = 0;
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      rdata = 8'($urandom);
      bad   = ($urandom_range(0, 4) == 0);
      if (bad) exp_ferr++;
      else exp_q.push_back(rdata);
      send_frame(rdata, ~bad, 1'b0);
      tick(bad ? 2 + int'($urandom_range(0, 10)) : int'($urandom_range(0, 10)));
    end
    tick(4 * OS);
    rand_ready = 1'b0;
    bus.ready = 1'b1;
    tick(4);
    check("rnd_ferr", n_ferr, exp_ferr);
    check("rnd_overrun", n_ovr, 32'd0);
    check("rnd_all_received", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
